usb_uart_rx: RTL and testbench

UART receiver for the USB serial link. It deserialises the usb_rx line (8N1, LSB first) into bytes and buffers them in a small FIFO. Bytes are presented on a valid/ready stream to the command/pixel-loading logic in maincore. It is the receive counterpart of the existing usb_tx path.

---
 rtl/usb_uart_rx.sv | 202 ++++++++++++++++++++
 tb/tb_usb_uart_rx.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/usb_uart_rx.sv
// usb_uart_rx: UART receiver for the USB serial link (8N1, LSB first).
// Two-flop synchroniser, 16x oversampling with a 3-sample majority vote,
// and a small FIFO with a valid/ready output stream.
// Optional build macro USB_UART_RX_PARITY_EN switches the frame to 8E1 and
// adds the parity_err output.
module usb_uart_rx #(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          usb_rx,
  output logic [7:0]                    m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic                          frame_err,
  output logic                          overrun,
`ifdef USB_UART_RX_PARITY_EN
  output logic                          parity_err,
`endif
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int DIV = CLK_FREQ / (BAUD * 16);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int LW  = AW + 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK} state_e;

  state_e          state_q, state_d;
  logic            rx_m_q, rx_s_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      tidx_q, tidx_d;
  logic [2:0]      bitcnt_q, bitcnt_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            s7_q, s7_d, s8_q, s8_d;
  logic            push, ferr_set;
  logic            frame_err_q, overrun_q;
  logic            tick, decide, bit_end, dec;
`ifdef USB_UART_RX_PARITY_EN
  logic            par_ok_q, par_ok_d, perr_set, parity_err_q;
`endif

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wptr_q, rptr_q;
  logic [LW-1:0]   level_q;
  logic            full, pop, wr;

  // Two-flop synchroniser; idles high so reset never looks like a start bit
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m_q <= 1'b1;
      rx_s_q <= 1'b1;
    end else begin
      rx_m_q <= usb_rx;
      rx_s_q <= rx_m_q;
    end
  end

  assign tick    = (cnt_q == CW'(DIV - 1));
  assign decide  = tick && (tidx_q == 4'd9);
  assign bit_end = tick && (tidx_q == 4'd15);
  assign dec     = (s7_q & s8_q) | (s7_q & rx_s_q) | (s8_q & rx_s_q);

  // Next-state logic: receiver FSM plus oversample timing and shift register
  always_comb begin
    state_d  = state_q;
    cnt_d    = tick ? '0 : cnt_q + CW'(1);
    tidx_d   = tick ? tidx_q + 4'd1 : tidx_q;
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    s7_d     = (tick && tidx_q == 4'd7) ? rx_s_q : s7_q;
    s8_d     = (tick && tidx_q == 4'd8) ? rx_s_q : s8_q;
    push     = 1'b0;
    ferr_set = 1'b0;
`ifdef USB_UART_RX_PARITY_EN
    par_ok_d = par_ok_q;
    perr_set = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        // Timing held at zero so a frame starts counting from its falling edge
        cnt_d    = '0;
        tidx_d   = '0;
        bitcnt_d = '0;
        if (!rx_s_q) state_d = START;
      end
      START: begin
        if (decide && dec) state_d = IDLE;
        else if (bit_end)  state_d = DATA;
      end
      DATA: begin
        if (decide) shreg_d = {dec, shreg_q[7:1]};
        if (bit_end) begin
          bitcnt_d = bitcnt_q + 3'd1;
`ifdef USB_UART_RX_PARITY_EN
          if (bitcnt_q == 3'd7) state_d = PARITY;
`else
          if (bitcnt_q == 3'd7) state_d = STOP;
`endif
        end
      end
`ifdef USB_UART_RX_PARITY_EN
      PARITY: begin
        if (decide)  par_ok_d = ~(^shreg_q ^ dec);
        if (bit_end) state_d  = STOP;
      end
`endif
      STOP: begin
        // Leave at mid-stop so a back-to-back start edge is not missed
        if (decide) begin
          if (dec) begin
`ifdef USB_UART_RX_PARITY_EN
            if (par_ok_q) push = 1'b1;
            else          perr_set = 1'b1;
`else
            push = 1'b1;
`endif
            state_d = IDLE;
          end else begin
            ferr_set = 1'b1;
            state_d  = BRK;
          end
        end
      end
      BRK: begin
        if (rx_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Receiver state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      tidx_q      <= '0;
      bitcnt_q    <= '0;
      shreg_q     <= '0;
      s7_q        <= 1'b1;
      s8_q        <= 1'b1;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tidx_q      <= tidx_d;
      bitcnt_q    <= bitcnt_d;
      shreg_q     <= shreg_d;
      s7_q        <= s7_d;
      s8_q        <= s8_d;
      frame_err_q <= ferr_set;
    end
  end

`ifdef USB_UART_RX_PARITY_EN
  // Parity result and error pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      par_ok_q     <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      par_ok_q     <= par_ok_d;
      parity_err_q <= perr_set;
    end
  end
  assign parity_err = parity_err_q;
`endif

  assign full = (level_q == LW'(FIFO_DEPTH));
  assign pop  = m_valid & m_ready;
  // A pop frees the slot in the same cycle, so a full FIFO still accepts
  assign wr   = push & (~full | pop);

  // Output FIFO storage, pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      level_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (wr) begin
        mem_q[wptr_q] <= shreg_q;
        wptr_q        <= wptr_q + AW'(1);
      end
      if (pop) rptr_q <= rptr_q + AW'(1);
      level_q   <= level_q + LW'(wr) - LW'(pop);
      overrun_q <= push & ~wr;
    end
  end

  assign m_data     = mem_q[rptr_q];
  assign m_valid    = (level_q != '0);
  assign fifo_level = level_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_usb_uart_rx.sv
// Directed bench for usb_uart_rx: scoreboard queue of expected bytes, popped
// by a monitor whenever the stream handshakes.
module tb_usb_uart_rx;
  localparam int BIT = 864;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       usb_rx = 1'b1;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready = 1'b0;
  logic       frame_err, overrun;
  logic [4:0] fifo_level;
`ifdef USB_UART_RX_PARITY_EN
  logic       parity_err;
`endif

  usb_uart_rx dut (
    .clk(clk), .rst(rst), .usb_rx(usb_rx),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .frame_err(frame_err), .overrun(overrun),
`ifdef USB_UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int cyc = 0, ferr_n = 0, ovr_n = 0, vld_n = 0, pop_n = 0, pop_cyc = 0;
  logic [7:0] sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: pulse counters and scoreboard compare on each handshake
  always @(negedge clk) begin
    logic [7:0] e;
    if (!rst) begin
      if (frame_err) ferr_n++;
      if (overrun)   ovr_n++;
      if (m_valid)   vld_n++;
      if (m_valid && m_ready) begin
        chk("sb_pending", 32'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("m_data", 32'(m_data), 32'(e));
        end
        pop_n++;
        pop_cyc = cyc;
      end
    end
  end

  task automatic wclk(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [7:0] b, input logic stop_bit);
    usb_rx = 1'b0; wclk(BIT);
    for (int i = 0; i < 8; i++) begin usb_rx = b[i]; wclk(BIT); end
    usb_rx = stop_bit; wclk(BIT);
    usb_rx = 1'b1;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 200 && fifo_level != 0; i++) wclk(1);
    wclk(2);
    chk(tag, 32'(fifo_level), 0);
    chk({tag, "_sb"}, 32'(sb.size()), 0);
  endtask

  initial begin
    int f0, o0, p0, v0, t0;
    // Reset state and idle line
    wclk(3); rst = 1'b0; wclk(1);
    chk("rst_valid", 32'(m_valid), 0);
    chk("rst_level", 32'(fifo_level), 0);
    chk("rst_data",  32'(m_data), 0);
    chk("rst_ferr",  32'(frame_err), 0);
    chk("rst_ovr",   32'(overrun), 0);
    wclk(2000);
    chk("idle_valid", 32'(m_valid), 0);
    chk("idle_level", 32'(fifo_level), 0);
    chk("idle_ferr_n", 32'(ferr_n), 0);
    chk("idle_ovr_n",  32'(ovr_n), 0);

    // 0xA5 with ready high: single-cycle valid, latency from start edge
    m_ready = 1'b1;
    p0 = pop_n; v0 = vld_n; t0 = cyc;
    sb.push_back(8'hA5);
    send(8'hA5, 1'b1);
    wclk(BIT);
    chk("a5_pops", 32'(pop_n - p0), 1);
    chk("a5_vld_cycles", 32'(vld_n - v0), 1);
    chk("a5_latency", 32'((pop_cyc - t0) >= 8315 && (pop_cyc - t0) <= 8323), 1);

    // Short glitch is rejected; following byte received
    f0 = ferr_n; p0 = pop_n;
    usb_rx = 1'b0; wclk(300); usb_rx = 1'b1; wclk(2000);
    chk("glitch_ferr", 32'(ferr_n - f0), 0);
    chk("glitch_pops", 32'(pop_n - p0), 0);
    sb.push_back(8'h3C);
    send(8'h3C, 1'b1); wclk(BIT);
    chk("3c_pops", 32'(pop_n - p0), 1);

    // Bad stop bit followed by a held-low line: one frame error, no byte
    f0 = ferr_n; p0 = pop_n;
    send(8'h55, 1'b0);
    usb_rx = 1'b0; wclk(5 * BIT); usb_rx = 1'b1; wclk(2000);
    chk("brk_ferr", 32'(ferr_n - f0), 1);
    chk("brk_pops", 32'(pop_n - p0), 0);
    sb.push_back(8'h0F);
    send(8'h0F, 1'b1); wclk(BIT);
    chk("0f_pops", 32'(pop_n - p0), 1);

    // Fill with ready low: 17th byte overruns, drain in order
    m_ready = 1'b0; o0 = ovr_n;
    for (int i = 0; i < 17; i++) begin
      if (i < 16) sb.push_back(8'(i));
      send(8'(i), 1'b1);
    end
    wclk(BIT);
    chk("full_level", 32'(fifo_level), 16);
    chk("full_ovr", 32'(ovr_n - o0), 1);
    chk("full_head", 32'(m_data), 0);
    m_ready = 1'b1;
    drain("full_drain");

    // Reset mid-frame discards the partial byte and the FIFO contents
    m_ready = 1'b0;
    send(8'h77, 1'b1); wclk(BIT);
    chk("pre_rst_level", 32'(fifo_level), 1);
    usb_rx = 1'b0; wclk(BIT);
    usb_rx = 1'b1; wclk(4 * BIT + BIT / 2);
    rst = 1'b1; wclk(2); rst = 1'b0;
    wclk(4 * BIT);
    chk("mid_rst_level", 32'(fifo_level), 0);
    chk("mid_rst_valid", 32'(m_valid), 0);
    sb.push_back(8'h81);
    send(8'h81, 1'b1); wclk(BIT);
    chk("81_level", 32'(fifo_level), 1);
    m_ready = 1'b1;
    drain("81_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
